// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit type codes, port indices and router buffer sizing.
package noc_pkg;

  localparam int unsigned DW                                = 32;
  localparam int unsigned NUM_PORTS                         = 5;
  localparam int unsigned MULTICAST_ROUTER_BUFFER_DEPTH_LOG = 2;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } flit_type_e;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    WEST  = 3'd1,
    EAST  = 3'd2,
    NORTH = 3'd3,
    SOUTH = 3'd4
  } port_e;

  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO, 2**DEPTH_LOG entries; FWFT=1 exposes the head combinationally the cycle after it is written.
module fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH_LOG = 2,
  parameter bit          FWFT      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG:0] r_wptr;
  logic [DEPTH_LOG:0] r_rptr;
  logic               w_push;
  logic               w_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[DEPTH_LOG] != r_rptr[DEPTH_LOG]) &&
                   (r_wptr[DEPTH_LOG-1:0] == r_rptr[DEPTH_LOG-1:0]);
  assign w_push  = wr_en_i & ~full_o;
  assign w_pop   = rd_en_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[DEPTH_LOG-1:0]] <= wr_data_i;
  end

  if (FWFT) begin : g_fwft
    assign rd_data_o = r_mem[r_rptr[DEPTH_LOG-1:0]];
  end else begin : g_std
    logic [WIDTH-1:0] r_rd_data;
    always_ff @(posedge clk_i) begin
      if (rst_i)      r_rd_data <= '0;
      else if (w_pop) r_rd_data <= r_mem[r_rptr[DEPTH_LOG-1:0]];
    end
    assign rd_data_o = r_rd_data;
  end

endmodule

// File: rtl/multicast_router_eager_fork.sv
// Eager fork: each masked output takes its copy independently; pop fires once every masked output has taken it.
module eager_fork #(
  parameter int unsigned   N    = 5,
  parameter logic [N-1:0]  MASK = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [N-1:0] i_ready,
  output logic [N-1:0] o_valid,
  output logic         o_pop
);

  logic [N-1:0] r_done;
  logic [N-1:0] w_accept;
  logic         w_all_done;

  always_comb begin
    o_valid    = MASK & ~r_done & {N{i_valid}};
    w_accept   = o_valid & i_ready;
    w_all_done = &(~MASK | r_done | w_accept);
    o_pop      = i_valid & w_all_done;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_done <= '0;
    else if (o_pop) r_done <= '0;
    else            r_done <= r_done | w_accept;
  end

endmodule

// File: rtl/multicast_router.sv
// Multicast router: buffers flits from one selected input port and replicates each to every port in output_mask.
module multicast_router
  import noc_pkg::*;
#(
  parameter logic [4:0]  input_sel   = 5'b00001,
  parameter logic [4:0]  output_mask = 5'b00000,
  parameter int unsigned DEPTH_LOG   = MULTICAST_ROUTER_BUFFER_DEPTH_LOG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0][DW-1:0]   data_i,
  input  logic [4:0]           valid_i,
  output logic [4:0]           ready_o,
  output logic [4:0][DW-1:0]   data_o,
  output logic [4:0]           valid_o,
  input  logic [4:0]           ready_i
);

  if (output_mask == '0) begin : g_err_mask
    $error("multicast_router: output_mask must not be zero");
  end
  if (!is_onehot(input_sel)) begin : g_err_sel
    $error("multicast_router: input_sel must be one-hot");
  end
  if ((input_sel & output_mask) != '0) begin : g_err_uturn
    $error("multicast_router: input_sel overlaps output_mask (U-turn)");
  end

  logic [DW-1:0] w_sel_data;
  logic          w_sel_valid;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_head_valid;
  logic [DW-1:0] w_head;

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (input_sel[k]) begin
        w_sel_data  = data_i[k];
        w_sel_valid = valid_i[k];
      end
    end
  end

  // Ready and head-valid are held low while rst is asserted so nothing moves during reset.
  assign w_ready      = ~w_full & ~rst;
  assign w_push       = w_sel_valid & w_ready;
  assign w_head_valid = ~w_empty & ~rst;
  assign ready_o      = input_sel & {5{w_ready}};

  fifo #(
    .WIDTH     (DW),
    .DEPTH_LOG (DEPTH_LOG),
    .FWFT      (1'b1)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (w_push),
    .wr_data_i (w_sel_data),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  eager_fork #(
    .N    (5),
    .MASK (output_mask)
  ) u_fork (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (w_head_valid),
    .i_ready (ready_i),
    .o_valid (valid_o),
    .o_pop   (w_pop)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      data_o[k] = (output_mask[k] && w_head_valid) ? w_head : '0;
    end
  end

endmodule

// File: tb/tb_multicast_router.sv
// Directed bench for multicast_router: west input, local/east/south outputs, depth 4.
module tb_multicast_router;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0][31:0] data_i;
  logic [4:0]       valid_i;
  logic [4:0]       ready_o;
  logic [4:0][31:0] data_o;
  logic [4:0]       valid_o;
  logic [4:0]       ready_i;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q2[$];
  logic [31:0] q4[$];
  bit          side_valid = 1'b0;

  logic [31:0] f4 [6];
  logic [31:0] exp5 [100];
  int          idx;
  int          bad;

  always #5 clk = ~clk;

  multicast_router #(
    .input_sel   (5'b00010),
    .output_mask (5'b10101),
    .DEPTH_LOG   (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always @(posedge clk) begin
    if (valid_o[1] | valid_o[3]) side_valid = 1'b1;
    if (rst === 1'b0) begin
      if (valid_o[0] & ready_i[0]) q0.push_back(data_o[0]);
      if (valid_o[2] & ready_i[2]) q2.push_back(data_o[2]);
      if (valid_o[4] & ready_i[4]) q4.push_back(data_o[4]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    f4 = '{32'h0000_0A00, 32'h4000_0A01, 32'h4000_0A02,
           32'h4000_0A03, 32'h4000_0A04, 32'h8000_0A05};

    // 1. reset with west valid asserted
    rst     = 1'b1;
    data_i  = '0;
    data_i[1] = 32'hDEAD_BEEF;
    valid_i = 5'b00010;
    ready_i = 5'b10101;
    for (int i = 0; i < 3; i++) begin
      next();
      chk("rst_valid_o", valid_o, 5'b00000);
      chk("rst_ready_o1", ready_o[1], 1'b0);
    end
    rst     = 1'b0;
    valid_i = 5'b00000;
    ready_i = 5'b00000;
    #1;
    chk("post_rst_ready_o", ready_o, 5'b00010);
    chk("post_rst_valid_o", valid_o, 5'b00000);
    chk("post_rst_data_o0", data_o[0], 32'h0);
    next();
    chk("rst_nothing_pushed", valid_o, 5'b00000);

    // 2. single flit, all outputs ready
    data_i[1] = 32'h4000_0001;
    valid_i   = 5'b00010;
    ready_i   = 5'b10101;
    #1;
    chk("single_ready", ready_o[1], 1'b1);
    next();
    valid_i = 5'b00000;
    #1;
    chk("single_valid_o", valid_o, 5'b10101);
    chk("single_data0", data_o[0], 32'h4000_0001);
    chk("single_data2", data_o[2], 32'h4000_0001);
    chk("single_data4", data_o[4], 32'h4000_0001);
    chk("single_data1_tied", data_o[1], 32'h0);
    chk("single_data3_tied", data_o[3], 32'h0);
    next();
    #1;
    chk("single_retired", valid_o, 5'b00000);
    chk("single_data0_empty", data_o[0], 32'h0);

    // 3. staggered acceptance
    q0.delete(); q2.delete(); q4.delete();
    data_i[1] = 32'h8000_0002;
    valid_i   = 5'b00010;
    ready_i   = 5'b00000;
    next();
    valid_i = 5'b00000;
    ready_i = 5'b00001;
    #1; chk("stag_c1_valid", valid_o, 5'b10101);
    next();
    ready_i = 5'b00000;
    #1; chk("stag_c2_valid", valid_o, 5'b10100);
    next();
    ready_i = 5'b00100;
    #1; chk("stag_c3_valid", valid_o, 5'b10100);
    next();
    ready_i = 5'b00000;
    #1; chk("stag_c4_valid", valid_o, 5'b10000);
    next();
    ready_i = 5'b10000;
    #1; chk("stag_c5_valid", valid_o, 5'b10000);
    chk("stag_c5_data4", data_o[4], 32'h8000_0002);
    next();
    ready_i = 5'b10101;
    #1; chk("stag_c6_popped", valid_o, 5'b00000);
    next();
    chk("stag_copies0", q0.size(), 1);
    chk("stag_copies2", q2.size(), 1);
    chk("stag_copies4", q4.size(), 1);
    if (q4.size() > 0) chk("stag_q4_data", q4[0], 32'h8000_0002);

    // 4. backpressure to full with south stalled
    q0.delete(); q2.delete(); q4.delete();
    ready_i = 5'b00101;
    for (int i = 0; i < 4; i++) begin
      data_i[1] = f4[i];
      valid_i   = 5'b00010;
      #1; chk("bp_fill_ready", ready_o[1], 1'b1);
      next();
    end
    data_i[1] = f4[4];
    #1;
    chk("bp_full_ready", ready_o[1], 1'b0);
    chk("bp_full_valid", valid_o, 5'b10000);
    next();
    ready_i = 5'b10101;
    #1;
    chk("bp_conservative_ready", ready_o[1], 1'b0);
    next();
    idx = 4;
    for (int cyc = 0; cyc < 20 && idx < 6; cyc++) begin
      data_i[1] = f4[idx];
      valid_i   = 5'b00010;
      #1;
      if (ready_o[1]) idx++;
      next();
    end
    chk("bp_push_bound", idx, 6);
    valid_i = 5'b00000;
    for (int i = 0; i < 10; i++) next();
    chk("bp_count0", q0.size(), 6);
    chk("bp_count2", q2.size(), 6);
    chk("bp_count4", q4.size(), 6);
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      if (j < q0.size() && q0[j] !== f4[j]) bad++;
      if (j < q2.size() && q2[j] !== f4[j]) bad++;
      if (j < q4.size() && q4[j] !== f4[j]) bad++;
    end
    chk("bp_order", bad, 0);

    // 5. streaming with all outputs ready
    q0.delete(); q2.delete(); q4.delete();
    ready_i = 5'b10101;
    for (int i = 0; i < 100; i++) begin
      exp5[i]   = $urandom;
      data_i[1] = exp5[i];
      valid_i   = 5'b00010;
      #1;
      chk("stream_ready", ready_o[1], 1'b1);
      if (i > 0) begin
        chk("stream_valid", valid_o, 5'b10101);
        chk("stream_data2", data_o[2], exp5[i-1]);
      end
      next();
    end
    valid_i = 5'b00000;
    #1;
    chk("stream_last_valid", valid_o, 5'b10101);
    chk("stream_last_data4", data_o[4], exp5[99]);
    next();
    #1; chk("stream_drained", valid_o, 5'b00000);
    chk("stream_count0", q0.size(), 100);
    chk("stream_count2", q2.size(), 100);
    chk("stream_count4", q4.size(), 100);
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      if (j < q0.size() && q0[j] !== exp5[j]) bad++;
      if (j < q2.size() && q2[j] !== exp5[j]) bad++;
      if (j < q4.size() && q4[j] !== exp5[j]) bad++;
    end
    chk("stream_order", bad, 0);
    chk("ports13_never_valid", side_valid, 1'b0);

    // 6. reset after the head went out on port 0 only
    q0.delete(); q2.delete(); q4.delete();
    ready_i   = 5'b00000;
    data_i[1] = 32'h0000_0C00;
    valid_i   = 5'b00010;
    next();
    data_i[1] = 32'h0000_0C01;
    #1; chk("mid_push2_ready", ready_o[1], 1'b1);
    next();
    valid_i = 5'b00000;
    ready_i = 5'b00001;
    #1;
    chk("mid_pre_valid", valid_o, 5'b10101);
    chk("mid_pre_data0", data_o[0], 32'h0000_0C00);
    next();
    rst     = 1'b1;
    ready_i = 5'b10101;
    #1; chk("mid_rst_valid", valid_o, 5'b00000);
    next();
    rst = 1'b0;
    #1;
    chk("mid_post_valid", valid_o, 5'b00000);
    chk("mid_post_ready", ready_o, 5'b00010);
    next();
    #1; chk("mid_post_empty", valid_o, 5'b00000);
    data_i[1] = 32'h0000_0C02;
    valid_i   = 5'b00010;
    next();
    valid_i = 5'b00000;
    #1;
    chk("mid_next_valid", valid_o, 5'b10101);
    chk("mid_next_data2", data_o[2], 32'h0000_0C02);
    next();
    #1; chk("mid_next_retired", valid_o, 5'b00000);
    chk("mid_q0_count", q0.size(), 2);
    chk("mid_q2_count", q2.size(), 1);
    chk("mid_q4_count", q4.size(), 1);
    if (q0.size() > 1) chk("mid_q0_second", q0[1], 32'h0000_0C02);
    if (q2.size() > 0) chk("mid_q2_first", q2[0], 32'h0000_0C02);
    if (q4.size() > 0) chk("mid_q4_first", q4[0], 32'h0000_0C02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
